// File: rtl/shift_add_multiplier.sv
// Sequential 16x16 unsigned shift-and-add multiplier with start/busy/done handshake.
// Optional build macro EARLY_TERM_EN finishes as soon as no set multiplier bits remain.

module submultiplier #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic             bit_sel,
    output logic [WIDTH-1:0] anded
);
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_and
            assign anded[gi] = a[gi] & bit_sel;
        end
    endgenerate
endmodule

module shift_add_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state_reg;
    logic [WIDTH-1:0]     mcand_reg;
    logic [WIDTH-1:0]     mplier_reg;
    logic [2*WIDTH-1:0]   acc_reg;
    logic [CW-1:0]        count_reg;
    logic                 ready_reg;
    logic                 busy_reg;
    logic                 done_reg;
    logic [2*WIDTH-1:0]   product_reg;

    logic [WIDTH-1:0]     pp;
    logic [2*WIDTH-1:0]   acc_next;
    logic                 last_iter;

    submultiplier #(.WIDTH(WIDTH)) u_submultiplier (
        .a       (mcand_reg),
        .bit_sel (mplier_reg[0]),
        .anded   (pp)
    );

    // Partial product for bit i lands at weight 2^i; the sum never exceeds 2*WIDTH bits.
    assign acc_next = acc_reg + ({{WIDTH{1'b0}}, pp} << count_reg);

`ifdef EARLY_TERM_EN
    assign last_iter = (mplier_reg[WIDTH-1:1] == '0) || (count_reg == CW'(WIDTH - 1));
`else
    assign last_iter = (count_reg == CW'(WIDTH - 1));
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            mcand_reg   <= '0;
            mplier_reg  <= '0;
            acc_reg     <= '0;
            count_reg   <= '0;
            ready_reg   <= 1'b1;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            product_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start && ready_reg) begin
                        mcand_reg  <= a;
                        mplier_reg <= b;
                        acc_reg    <= '0;
                        count_reg  <= '0;
                        busy_reg   <= 1'b1;
                        ready_reg  <= 1'b0;
                        state_reg  <= RUN;
                    end
                end
                RUN: begin
                    acc_reg    <= acc_next;
                    mplier_reg <= mplier_reg >> 1;
                    count_reg  <= count_reg + 1'b1;
                    if (last_iter) begin
                        product_reg <= acc_next;
                        done_reg    <= 1'b1;
                        busy_reg    <= 1'b0;
                        ready_reg   <= 1'b1;
                        state_reg   <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign ready   = ready_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;
    assign product = product_reg;
endmodule
